main_control_fsm: RTL and testbench

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/main_control_fsm.sv | 221 ++++++++++++++++++++++
 tb/tb_main_control_fsm.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_control_fsm.sv
// Multicycle MIPS-style main control unit.
// A single state register walks each instruction through its phases. The
// datapath strobes are decoded combinationally from the current state, the
// latched opcode (op_q) and mem_ready. Every strobe is held at zero while
// reset_n is low.
module main_control_fsm (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [2:0] ALUOp,
   output logic       ALUSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       IorD,
   output logic       Jump,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       illegal_op
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      IMMEX   = 4'd9,
      IMMWB   = 4'd10,
      JEX     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;
   localparam logic [2:0] ALU_SLT   = 3'b101;

   state_t     state_r;
   logic [5:0] op_q;

   // The zero flag is ANDed with PCWriteCond inside the datapath, so the
   // controller itself never needs to look at it.
   logic unused_zero_s;
   assign unused_zero_s = zero;

   // True for every opcode this controller knows how to sequence.
   function automatic logic is_supported(input logic [5:0] op);
      logic ok;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI,
         OP_ANDI, OP_ORI, OP_SLTI, OP_J: ok = 1'b1;
         default:                         ok = 1'b0;
      endcase
      return ok;
   endfunction

   // ALU operation for the immediate-arithmetic group, chosen by the latched opcode.
   function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
      logic [2:0] alu;
      case (op)
         OP_ADDI: alu = ALU_ADD;
         OP_ANDI: alu = ALU_AND;
         OP_ORI:  alu = ALU_OR;
         OP_SLTI: alu = ALU_SLT;
         default: alu = ALU_ADD;
      endcase
      return alu;
   endfunction

   // State sequencing and opcode capture. Reset drops straight to FETCH.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= FETCH;
         op_q    <= 6'b000000;
      end else begin
         case (state_r)
            FETCH: begin
               if (mem_ready) state_r <= DECODE;
               else           state_r <= FETCH;
            end
            DECODE: begin
               op_q <= opcode;
               case (opcode)
                  OP_LW, OP_SW:                       state_r <= MEMADR;
                  OP_RTYPE:                           state_r <= RTYPEEX;
                  OP_BEQ:                             state_r <= BEQEX;
                  OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_r <= IMMEX;
                  OP_J:                               state_r <= JEX;
                  default:                            state_r <= FETCH;
               endcase
            end
            MEMADR: begin
               if (op_q == OP_LW)      state_r <= MEMRD;
               else if (op_q == OP_SW) state_r <= MEMWR;
               else                    state_r <= FETCH;
            end
            MEMRD: begin
               if (mem_ready) state_r <= MEMWB;
               else           state_r <= MEMRD;
            end
            MEMWR: begin
               if (mem_ready) state_r <= FETCH;
               else           state_r <= MEMWR;
            end
            RTYPEEX: state_r <= RTYPEWB;
            IMMEX:   state_r <= IMMWB;
            MEMWB, RTYPEWB, BEQEX, IMMWB, JEX: state_r <= FETCH;
            default: state_r <= FETCH;
         endcase
      end
   end

   // Strobe decode. Everything defaults to zero; reset_n low keeps it there.
   always_comb begin
      ALUOp       = ALU_ADD;
      ALUSrc      = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      IorD        = 1'b0;
      Jump        = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      if (!reset_n) begin
         ALUOp = ALU_ADD;
      end else begin
         case (state_r)
            FETCH: begin
               MemRead = 1'b1;
               if (mem_ready) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
               end else begin
                  IRWrite = 1'b0;
               end
            end
            DECODE: begin
               illegal_op = ~is_supported(opcode);
            end
            MEMADR: begin
               ALUOp  = ALU_ADD;
               ALUSrc = 1'b1;
            end
            MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            MEMWB: begin
               RegWrite   = 1'b1;
               MemtoReg   = 1'b1;
               instr_done = 1'b1;
            end
            MEMWR: begin
               MemWrite   = 1'b1;
               IorD       = 1'b1;
               instr_done = mem_ready;
            end
            RTYPEEX: begin
               ALUOp = ALU_FUNCT;
            end
            RTYPEWB: begin
               RegWrite   = 1'b1;
               RegDst     = 1'b1;
               instr_done = 1'b1;
            end
            BEQEX: begin
               ALUOp       = ALU_SUB;
               PCWriteCond = 1'b1;
               instr_done  = 1'b1;
            end
            IMMEX: begin
               ALUOp  = imm_alu_op(op_q);
               ALUSrc = 1'b1;
            end
            IMMWB: begin
               RegWrite   = 1'b1;
               instr_done = 1'b1;
            end
            JEX: begin
               PCWrite    = 1'b1;
               Jump       = 1'b1;
               instr_done = 1'b1;
            end
            default: begin
               ALUOp = ALU_ADD;
            end
         endcase
      end
   end

   assign state = state_r;

endmodule

// File: tb/tb_main_control_fsm.sv
// Randomised, self-checking bench for main_control_fsm. Each instruction is
// expanded by a reference model into the cycle-by-cycle trace the control
// table prescribes, then replayed against the DUT.
module tb_main_control_fsm;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic [2:0] ALUOp;
   logic       ALUSrc, IRWrite, PCWrite, PCWriteCond, MemRead, MemWrite;
   logic       RegWrite, RegDst, MemtoReg, IorD, Jump, instr_done, illegal_op;
   logic [3:0] state;

   int checks   = 0;
   int failures = 0;

   main_control_fsm dut (
      .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .IorD(IorD), .Jump(Jump),
      .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
   );

   always #5 clock = ~clock;

   // Output bundle: {ALUOp, ALUSrc, IRWrite, PCWrite, PCWriteCond, MemRead,
   // MemWrite, RegWrite, RegDst, MemtoReg, IorD, Jump, instr_done, illegal_op}
   logic [15:0] dut_vec;
   assign dut_vec = {ALUOp, ALUSrc, IRWrite, PCWrite, PCWriteCond, MemRead,
                     MemWrite, RegWrite, RegDst, MemtoReg, IorD, Jump,
                     instr_done, illegal_op};

   localparam logic [15:0] B_ILL   = 16'h0001;
   localparam logic [15:0] B_DONE  = 16'h0002;
   localparam logic [15:0] B_JUMP  = 16'h0004;
   localparam logic [15:0] B_IORD  = 16'h0008;
   localparam logic [15:0] B_M2R   = 16'h0010;
   localparam logic [15:0] B_RDST  = 16'h0020;
   localparam logic [15:0] B_RW    = 16'h0040;
   localparam logic [15:0] B_MW    = 16'h0080;
   localparam logic [15:0] B_MR    = 16'h0100;
   localparam logic [15:0] B_PCC   = 16'h0200;
   localparam logic [15:0] B_PCW   = 16'h0400;
   localparam logic [15:0] B_IRW   = 16'h0800;
   localparam logic [15:0] B_ASRC  = 16'h1000;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI = 6'b001101, OP_SLTI = 6'b001010, OP_J = 6'b000010;

   typedef struct {
      logic [3:0]  st;
      logic        mr;
      logic [15:0] vec;
   } step_t;

   step_t q[$];
   logic [5:0] legal_ops [9] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI,
                                 OP_ANDI, OP_ORI, OP_SLTI, OP_J};

   // Per-instruction observations taken from the DUT during replay.
   int obs_done_at, obs_done_cnt, obs_irw, obs_mw, obs_rw, obs_mr, obs_ill, obs_rw_m2r;

   function automatic logic is_legal(input logic [5:0] op);
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [15:0] aluop_bits(input logic [2:0] a);
      logic [15:0] v;
      v = 16'h0000;
      v[15:13] = a;
      return v;
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Build the expected trace for one instruction, replay it, and record observations.
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                            input logic zval, input logic [5:0] alt_op, input string tag);
      step_t s;
      logic  past_decode;
      q.delete();
      for (int i = 0; i < fw; i++) q.push_back('{4'd0, 1'b0, B_MR});
      q.push_back('{4'd0, 1'b1, B_MR | B_IRW | B_PCW});
      q.push_back('{4'd1, rnd_bit(), is_legal(op) ? 16'h0000 : B_ILL});
      case (op)
         OP_LW: begin
            q.push_back('{4'd2, rnd_bit(), B_ASRC});
            for (int i = 0; i < mw; i++) q.push_back('{4'd3, 1'b0, B_MR | B_IORD});
            q.push_back('{4'd3, 1'b1, B_MR | B_IORD});
            q.push_back('{4'd4, rnd_bit(), B_RW | B_M2R | B_DONE});
         end
         OP_SW: begin
            q.push_back('{4'd2, rnd_bit(), B_ASRC});
            for (int i = 0; i < mw; i++) q.push_back('{4'd5, 1'b0, B_MW | B_IORD});
            q.push_back('{4'd5, 1'b1, B_MW | B_IORD | B_DONE});
         end
         OP_R: begin
            q.push_back('{4'd6, rnd_bit(), aluop_bits(3'b010)});
            q.push_back('{4'd7, rnd_bit(), B_RW | B_RDST | B_DONE});
         end
         OP_BEQ: q.push_back('{4'd8, rnd_bit(), aluop_bits(3'b001) | B_PCC | B_DONE});
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
            q.push_back('{4'd9, rnd_bit(), B_ASRC | aluop_bits(
               (op == OP_ADDI) ? 3'b000 : (op == OP_ANDI) ? 3'b011 :
               (op == OP_ORI)  ? 3'b100 : 3'b101)});
            q.push_back('{4'd10, rnd_bit(), B_RW | B_DONE});
         end
         OP_J: q.push_back('{4'd11, rnd_bit(), B_PCW | B_JUMP | B_DONE});
         default: ;
      endcase
      obs_done_at = -1; obs_done_cnt = 0; obs_irw = 0; obs_mw = 0;
      obs_rw = 0; obs_mr = 0; obs_ill = 0; obs_rw_m2r = 0;
      past_decode = 1'b0;
      foreach (q[i]) begin
         s = q[i];
         opcode    = past_decode ? alt_op : op;
         mem_ready = s.mr;
         zero      = zval;
         #1;
         checks++;
         if (state !== s.st) begin
            failures++;
            $display("FAIL %s state cyc=%0d got=%0d exp=%0d", tag, i, state, s.st);
         end
         checks++;
         if (dut_vec !== s.vec) begin
            failures++;
            $display("FAIL %s outputs cyc=%0d got=%h exp=%h", tag, i, dut_vec, s.vec);
         end
         checks++;
         if (MemWrite === 1'b1 && RegWrite === 1'b1) begin
            failures++;
            $display("FAIL %s mw_rw_excl cyc=%0d got=11 exp=not-both", tag, i);
         end
         if (instr_done === 1'b1) begin
            obs_done_cnt++;
            if (obs_done_at < 0) obs_done_at = i + 1;
         end
         if (IRWrite === 1'b1)  obs_irw++;
         if (MemWrite === 1'b1) obs_mw++;
         if (RegWrite === 1'b1) obs_rw++;
         if (RegWrite === 1'b1 && MemtoReg === 1'b1) obs_rw_m2r++;
         if (MemRead === 1'b1)  obs_mr++;
         if (illegal_op === 1'b1) obs_ill++;
         if (s.st == 4'd1) past_decode = 1'b1;
         @(negedge clock);
      end
      checks++;
      if (state !== 4'd0) begin
         failures++;
         $display("FAIL %s return_to_fetch got=%0d exp=0", tag, state);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; mem_ready = 1'b1; opcode = OP_LW; zero = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      checks++;
      if (state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++;
      if (dut_vec !== 16'h0000) begin failures++; $display("FAIL reset_outputs got=%h exp=0000", dut_vec); end
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_lw();
      run_instr(OP_LW, 0, 0, 1'b0, OP_LW, "lw");
      checks++;
      if (obs_mr !== 2) begin failures++; $display("FAIL lw_memread_cycles got=%0d exp=2", obs_mr); end
      checks++;
      if (obs_rw_m2r !== 1 || obs_rw !== 1) begin
         failures++; $display("FAIL lw_regwrite got=%0d exp=1", obs_rw);
      end
      checks++;
      if (obs_done_cnt !== 1) begin failures++; $display("FAIL lw_done_count got=%0d exp=1", obs_done_cnt); end
   endtask

   task automatic test_rtype_imm_hold();
      run_instr(OP_R, 0, 0, 1'b0, OP_R, "rtype");
      run_instr(OP_ORI, 0, 0, 1'b0, OP_J, "ori_hold");
   endtask

   task automatic test_beq();
      run_instr(OP_BEQ, 0, 0, 1'b1, OP_BEQ, "beq_z1");
      checks++;
      if (obs_done_at !== 3) begin failures++; $display("FAIL beq_z1_cycles got=%0d exp=3", obs_done_at); end
      run_instr(OP_BEQ, 0, 0, 1'b0, OP_BEQ, "beq_z0");
      checks++;
      if (obs_done_at !== 3) begin failures++; $display("FAIL beq_z0_cycles got=%0d exp=3", obs_done_at); end
   endtask

   task automatic test_sw_stall();
      run_instr(OP_SW, 3, 2, 1'b0, OP_SW, "sw_stall");
      checks++;
      if (obs_irw !== 1) begin failures++; $display("FAIL sw_irwrite got=%0d exp=1", obs_irw); end
      checks++;
      if (obs_mw !== 3) begin failures++; $display("FAIL sw_memwrite got=%0d exp=3", obs_mw); end
      checks++;
      if (obs_done_at !== 9) begin failures++; $display("FAIL sw_cycles got=%0d exp=9", obs_done_at); end
   endtask

   task automatic test_illegal();
      run_instr(6'b111111, 0, 0, 1'b0, 6'b111111, "illegal");
      checks++;
      if (obs_ill !== 1) begin failures++; $display("FAIL illegal_pulse got=%0d exp=1", obs_ill); end
      checks++;
      if (obs_rw !== 0 || obs_mw !== 0) begin
         failures++; $display("FAIL illegal_writes got=%0d exp=0", obs_rw + obs_mw);
      end
   endtask

   task automatic test_cycle_counts();
      logic [5:0] ops [6] = '{OP_LW, OP_SW, OP_R, OP_ADDI, OP_BEQ, OP_J};
      int         exp [6] = '{5, 4, 4, 4, 3, 3};
      for (int i = 0; i < 6; i++) begin
         run_instr(ops[i], 0, 0, rnd_bit(), ops[i], "count");
         checks++;
         if (obs_done_at !== exp[i]) begin
            failures++;
            $display("FAIL cycles op=%b got=%0d exp=%0d", ops[i], obs_done_at, exp[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [5:0] op;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 9) == 0) op = 6'($urandom);
         else op = legal_ops[$urandom_range(0, 8)];
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rnd_bit(),
                   6'($urandom), "random");
      end
   endtask

   task automatic test_async_reset();
      logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
      opcode = OP_LW;
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i < 2) ? 1'b1 : 1'b0;
         #1;
         checks++;
         if (state !== seq[i]) begin
            failures++; $display("FAIL async_walk cyc=%0d got=%0d exp=%0d", i, state, seq[i]);
         end
         if (i < 3) @(negedge clock);
      end
      #1;
      reset_n = 1'b0;
      #1;
      checks++;
      if (state !== 4'd0) begin failures++; $display("FAIL async_state got=%0d exp=0", state); end
      checks++;
      if (dut_vec !== 16'h0000) begin failures++; $display("FAIL async_outputs got=%h exp=0000", dut_vec); end
      mem_ready = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (state !== 4'd0 || dut_vec !== 16'h0000) begin
         failures++; $display("FAIL async_hold got=%0d/%h exp=0/0000", state, dut_vec);
      end
      @(negedge clock);
      reset_n = 1'b1;
      run_instr(OP_ANDI, 1, 0, 1'b0, OP_ANDI, "after_reset");
   endtask

   initial begin
      test_reset();
      test_lw();
      test_rtype_imm_hold();
      test_beq();
      test_sw_stall();
      test_illegal();
      test_cycle_counts();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
